// File: rtl/trace_pkg.sv
// trace_pkg
// Shared definitions for the CPU commit-trace recorder: the packed entry
// layout, the word order used by the serializer and the serializer states.
// No ports; imported by trace_fifo and cpu_trace_buffer.
package trace_pkg;

    // Entry layout, MSB first: {pc, inst, rf_wena, rf_waddr, rf_wdata}
    localparam int TRACE_W   = 102;
    localparam int WDATA_LSB = 0;
    localparam int WADDR_LSB = 32;
    localparam int WENA_BIT  = 37;
    localparam int INST_LSB  = 38;
    localparam int PC_LSB    = 70;

    // Order in which the four words of an entry leave the serializer
    localparam logic [1:0] WORD_PC    = 2'd0;
    localparam logic [1:0] WORD_INST  = 2'd1;
    localparam logic [1:0] WORD_RF    = 2'd2;
    localparam logic [1:0] WORD_WDATA = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_W1,
        ST_W2,
        ST_W3
    } ser_state_t;

    function automatic logic [TRACE_W-1:0] pack_entry(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        wena,
        input logic [4:0]  waddr,
        input logic [31:0] wdata
    );
        return {pc, inst, wena, waddr, wdata};
    endfunction

    // The register-write word carries the enable in bit 31 and the
    // destination register in the low five bits.
    function automatic logic [31:0] entry_word(
        input logic [TRACE_W-1:0] entry,
        input logic [1:0]         idx
    );
        logic [31:0] word;
        case (idx)
            WORD_PC:   word = entry[PC_LSB +: 32];
            WORD_INST: word = entry[INST_LSB +: 32];
            WORD_RF:   word = {entry[WENA_BIT], 26'b0, entry[WADDR_LSB +: 5]};
            default:   word = entry[WDATA_LSB +: 32];
        endcase
        return word;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
// Synchronous FIFO with a combinational head (no read latency).
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   push, wdata   write an entry at the tail
//   pop           drop the head entry
//   rdata         current head entry
//   full, empty   occupancy == DEPTH / occupancy == 0
//   count         occupancy, ADDR_W+1 bits
// The owner never pushes into a full FIFO unless it pops in the same cycle,
// and never pops an empty one.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int WIDTH  = TRACE_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; a simultaneous push and pop leaves
    // the occupancy unchanged even when full, since the head is consumed
    // from the combinational read port in that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
// Captures one retiring-instruction record per enabled clock into a FIFO and
// streams each record out as four 32-bit words over a valid/ready interface.
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   trace_en                     capture enable
//   pc, inst                     retiring instruction address and word
//   rf_wena, rf_waddr, rf_wdata  register-file write port
//   out_valid, out_ready         word handshake
//   out_data, out_last           word and end-of-entry marker
//   full, empty                  FIFO status
//   overflow, drop_count         sticky drop flag and saturating drop count
//   rec_count, done              accepted entries and record limit reached
module cpu_trace_buffer
    import trace_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter int          ADDR_W      = 4,
    parameter logic [31:0] MAX_RECORDS = 32'h0000_0230
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_en,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        rf_wena,
    input  logic [4:0]  rf_waddr,
    input  logic [31:0] rf_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic [15:0] drop_count,
    output logic [31:0] rec_count,
    output logic        done
);

    localparam logic [ADDR_W:0] DEPTH_COUNT = (ADDR_W + 1)'(DEPTH);

    ser_state_t         state;
    ser_state_t         state_next;
    logic [TRACE_W-1:0] entry_q;
    logic [TRACE_W-1:0] head;
    logic [ADDR_W:0]    occupancy;
    logic               cap;
    logic               push_ok;
    logic               pop;
    logic [1:0]         word_idx;

    assign done    = (rec_count == MAX_RECORDS);
    assign cap     = trace_en && !done;
    assign push_ok = cap && ((occupancy < DEPTH_COUNT) || pop);

    trace_fifo #(
        .WIDTH  (TRACE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .wdata (pack_entry(pc, inst, rf_wena, rf_waddr, rf_wdata)),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    // Accepted and dropped entries are counted here; once the record limit
    // is reached cap stays low, so neither counter moves again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_count  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push_ok) begin
                rec_count <= rec_count + 32'd1;
            end
            if (cap && !push_ok) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    // Serializer state and the output entry register; the head entry is
    // copied out of the FIFO at the moment it is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            entry_q <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                entry_q <= head;
            end
        end
    end

    // Next-state logic. Pops happen only when loading a new entry: from IDLE
    // whenever data is waiting, or straight out of an accepted W3 so that
    // consecutive entries stream without a bubble.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_W0;
                end
            end
            ST_W0: if (out_ready) state_next = ST_W1;
            ST_W1: if (out_ready) state_next = ST_W2;
            ST_W2: if (out_ready) state_next = ST_W3;
            ST_W3: begin
                if (out_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ST_W0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs depend only on registered state, so they hold steady while
    // the consumer stalls.
    always_comb begin
        word_idx  = WORD_PC;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state)
            ST_W0: word_idx = WORD_PC;
            ST_W1: word_idx = WORD_INST;
            ST_W2: word_idx = WORD_RF;
            ST_W3: word_idx = WORD_WDATA;
            default: word_idx = WORD_PC;
        endcase
        if (state != ST_IDLE) begin
            out_valid = 1'b1;
            out_data  = entry_word(entry_q, word_idx);
            out_last  = (state == ST_W3);
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer
// Directed bench for cpu_trace_buffer. A second instance with a record limit
// of 3 shares the stimulus and is only examined in the record-limit step.
module tb_cpu_trace_buffer;

    logic        clk;
    logic        rst;
    logic        trace_en;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rf_wena;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        out_ready;

    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [15:0] drop_count;
    logic [31:0] rec_count;
    logic        done;

    logic        lim_out_valid;
    logic [31:0] lim_out_data;
    logic        lim_out_last;
    logic        lim_full;
    logic        lim_empty;
    logic        lim_overflow;
    logic [15:0] lim_drop_count;
    logic [31:0] lim_rec_count;
    logic        lim_done;

    int checks = 0;
    int errors = 0;

    cpu_trace_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .trace_en   (trace_en),
        .pc         (pc),
        .inst       (inst),
        .rf_wena    (rf_wena),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .drop_count (drop_count),
        .rec_count  (rec_count),
        .done       (done)
    );

    cpu_trace_buffer #(.MAX_RECORDS(32'd3)) dut_lim (
        .clk        (clk),
        .rst        (rst),
        .trace_en   (trace_en),
        .pc         (pc),
        .inst       (inst),
        .rf_wena    (rf_wena),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .out_valid  (lim_out_valid),
        .out_ready  (out_ready),
        .out_data   (lim_out_data),
        .out_last   (lim_out_last),
        .full       (lim_full),
        .empty      (lim_empty),
        .overflow   (lim_overflow),
        .drop_count (lim_drop_count),
        .rec_count  (lim_rec_count),
        .done       (lim_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(
        input logic        en,
        input logic [31:0] p,
        input logic [31:0] i,
        input logic        we,
        input logic [4:0]  wa,
        input logic [31:0] wd,
        input logic        rdy
    );
        trace_en  = en;
        pc        = p;
        inst      = i;
        rf_wena   = we;
        rf_waddr  = wa;
        rf_wdata  = wd;
        out_ready = rdy;
    endtask

    task automatic checkOutput(
        input string       tag,
        input logic [31:0] observed,
        input logic [31:0] expected
    );
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Checks the word on offer at this negedge, then lets it be accepted.
    task automatic expectWord(input string tag, input logic [31:0] word, input logic last);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_data"}, out_data, word);
        checkOutput({tag, "_last"}, 32'(out_last), 32'(last));
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int   lim_words;
    int   lim_lasts;
    logic [31:0] lim_first;
    logic saw_valid;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        doReset();

        // Reset state
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", out_data, 32'd0);
        checkOutput("rst_last", 32'(out_last), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_drop", 32'(drop_count), 32'd0);
        checkOutput("rst_rec", rec_count, 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);

        // Single capture, consumer always ready
        $display("[TB] single capture");
        applyStimulus(1'b1, 32'h0040_0000, 32'h3C01_1001, 1'b1, 5'd1, 32'h1001_0000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        checkOutput("cap_empty", 32'(empty), 32'd0);
        checkOutput("cap_rec", rec_count, 32'd1);
        checkOutput("cap_valid_before_pop", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("cap_empty_after_pop", 32'(empty), 32'd1);
        expectWord("cap_w0", 32'h0040_0000, 1'b0);
        expectWord("cap_w1", 32'h3C01_1001, 1'b0);
        expectWord("cap_w2", 32'h8000_0001, 1'b0);
        expectWord("cap_w3", 32'h1001_0000, 1'b1);
        checkOutput("cap_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("cap_idle_empty", 32'(empty), 32'd1);

        // Backpressure held in W1 for five cycles
        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h0040_0000, 32'h3C01_1001, 1'b1, 5'd1, 32'h1001_0000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        expectWord("bp_w0", 32'h0040_0000, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_data", out_data, 32'h3C01_1001);
            @(negedge clk);
        end
        checkOutput("bp_hold_final", out_data, 32'h3C01_1001);
        out_ready = 1'b1;
        @(negedge clk);
        expectWord("bp_w2", 32'h8000_0001, 1'b0);
        expectWord("bp_w3", 32'h1001_0000, 1'b1);
        checkOutput("bp_idle", 32'(out_valid), 32'd0);
        checkOutput("bp_rec", rec_count, 32'd2);

        // Overflow with a stalled consumer. The first entry is popped into
        // the output register, so the FIFO fills on the 17th capture.
        $display("[TB] overflow");
        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(i), 32'hA000 + 32'(i), 1'b0, 5'(i), 32'(i), 1'b0);
            @(negedge clk);
            if (i == 15) checkOutput("ovf_not_full_yet", 32'(full), 32'd0);
        end
        checkOutput("ovf_full", 32'(full), 32'd1);
        checkOutput("ovf_rec17", rec_count, 32'd17);
        checkOutput("ovf_no_drop_yet", 32'(drop_count), 32'd0);
        checkOutput("ovf_flag_clear", 32'(overflow), 32'd0);
        checkOutput("ovf_head_word", out_data, 32'h0000_1000);
        for (int i = 17; i < 21; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(i), 32'hA000 + 32'(i), 1'b0, 5'(i), 32'(i), 1'b0);
            @(negedge clk);
        end
        checkOutput("ovf_drop4", 32'(drop_count), 32'd4);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_rec_held", rec_count, 32'd17);
        checkOutput("ovf_done", 32'(done), 32'd0);

        // Full FIFO draining while pushes continue: only the W3 pop edge of
        // each entry lets a push through.
        $display("[TB] full plus pop");
        applyStimulus(1'b1, 32'h2000, 32'hB000, 1'b0, 5'd0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("fp_full_a", 32'(full), 32'd1);
        end
        checkOutput("fp_next_entry_a", out_data, 32'h0000_1001);
        checkOutput("fp_drop_a", 32'(drop_count), 32'd7);
        checkOutput("fp_rec_a", rec_count, 32'd18);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("fp_full_b", 32'(full), 32'd1);
        end
        checkOutput("fp_next_entry_b", out_data, 32'h0000_1002);
        checkOutput("fp_drop_b", 32'(drop_count), 32'd10);
        checkOutput("fp_rec_b", rec_count, 32'd19);

        // Asynchronous reset while in W2 with five entries queued
        $display("[TB] reset mid-stream");
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'h3000 + 32'(i), 32'hC000 + 32'(i), 1'b1, 5'(i), 32'(i), 1'b0);
            @(negedge clk);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_w2_data", out_data, 32'h8000_0000);
        checkOutput("mid_queued", 32'(empty), 32'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_empty", 32'(empty), 32'd1);
        checkOutput("mid_rst_rec", rec_count, 32'd0);
        checkOutput("mid_rst_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("mid_no_stale", 32'(saw_valid), 32'd0);
        checkOutput("mid_after_empty", 32'(empty), 32'd1);

        // Record limit of 3 on the second instance
        $display("[TB] record limit");
        doReset();
        lim_words = 0;
        lim_lasts = 0;
        lim_first = '0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(i < 10, 32'h5000 + 32'(i), 32'hD000 + 32'(i), 1'b0, 5'd0, 32'(i), 1'b1);
            @(negedge clk);
            if (lim_out_valid) begin
                lim_words++;
                if (lim_words == 1) lim_first = lim_out_data;
                if (lim_out_last) lim_lasts++;
            end
        end
        checkOutput("lim_done", 32'(lim_done), 32'd1);
        checkOutput("lim_rec", lim_rec_count, 32'd3);
        checkOutput("lim_words", 32'(lim_words), 32'd12);
        checkOutput("lim_lasts", 32'(lim_lasts), 32'd3);
        checkOutput("lim_first", lim_first, 32'h0000_5000);
        checkOutput("lim_overflow", 32'(lim_overflow), 32'd0);
        checkOutput("lim_drop", 32'(lim_drop_count), 32'd0);
        checkOutput("lim_empty", 32'(lim_empty), 32'd1);
        checkOutput("lim_full", 32'(lim_full), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
